fabric_cfg_loader: RTL and testbench



---
 rtl/fabric_cfg_pkg.sv | 19 +
 rtl/cfg_strobe_decode.sv | 53 +++++
 rtl/fabric_cfg_loader.sv | 123 ++++++++++++
 tb/tb_fabric_cfg_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// Shared types and constants for the fabric configuration loader.
package fabric_cfg_pkg;

    localparam int BYTES_PER_BLOCK = 4;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_e;

    typedef enum logic [1:0] {
        FLD_X  = 2'd0,
        FLD_Y  = 2'd1,
        FLD_AB = 2'd2,
        FLD_CX = 2'd3
    } field_e;

    function automatic int blk_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cfg_strobe_decode.sv
// Registered decoder turning (fire, block, field) into one-cycle per-block write strobes.
module cfg_strobe_decode
    import fabric_cfg_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int BW         = blk_idx_w(NUM_BLOCKS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fire,
    input  logic [BW-1:0]         blk_idx,
    input  field_e                field,
    output logic [NUM_BLOCKS-1:0] set_x,
    output logic [NUM_BLOCKS-1:0] set_y,
    output logic [NUM_BLOCKS-1:0] set_ab,
    output logic [NUM_BLOCKS-1:0] set_cx
);

    logic [NUM_BLOCKS-1:0] blk_sel;
    logic [NUM_BLOCKS-1:0] set_x_d, set_y_d, set_ab_d, set_cx_d;
    logic [NUM_BLOCKS-1:0] set_x_q, set_y_q, set_ab_q, set_cx_q;

    always_comb begin
        blk_sel = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            blk_sel[i] = (blk_idx == BW'(i));
        end
        set_x_d  = (fire && field == FLD_X)  ? blk_sel : '0;
        set_y_d  = (fire && field == FLD_Y)  ? blk_sel : '0;
        set_ab_d = (fire && field == FLD_AB) ? blk_sel : '0;
        set_cx_d = (fire && field == FLD_CX) ? blk_sel : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_x_q  <= '0;
            set_y_q  <= '0;
            set_ab_q <= '0;
            set_cx_q <= '0;
        end else begin
            set_x_q  <= set_x_d;
            set_y_q  <= set_y_d;
            set_ab_q <= set_ab_d;
            set_cx_q <= set_cx_d;
        end
    end

    assign set_x  = set_x_q;
    assign set_y  = set_y_q;
    assign set_ab = set_ab_q;
    assign set_cx = set_cx_q;

endmodule

// File: rtl/fabric_cfg_loader.sv
// Streams config bytes into the LUT block array and validates the load with a trailing XOR checksum.
//   state | meaning
//   IDLE  | waiting for the first start
//   LOAD  | accepting payload bytes, one strobe per byte
//   CHECK | accepting the checksum byte
//   DONE  | load finished, err valid, waiting for start
module fabric_cfg_loader
    import fabric_cfg_pkg::*;
#(
    parameter int NUM_BLOCKS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            cfg_out,
    output logic [NUM_BLOCKS-1:0] set_x,
    output logic [NUM_BLOCKS-1:0] set_y,
    output logic [NUM_BLOCKS-1:0] set_ab,
    output logic [NUM_BLOCKS-1:0] set_cx,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int              BW       = blk_idx_w(NUM_BLOCKS);
    localparam logic [BW-1:0]   LAST_BLK = BW'(NUM_BLOCKS - 1);
    localparam field_e          LAST_FLD = field_e'(2'(BYTES_PER_BLOCK - 1));

    state_e        state_q, state_d;
    field_e        fld_q, fld_d;
    logic [BW-1:0] blk_q, blk_d;
    logic [7:0]    xor_q, xor_d;
    logic [7:0]    cfg_q, cfg_d;
    logic          err_q, err_d;
    logic          accept, fire;

    // start takes priority over data, so ready drops during a restart cycle
    assign busy     = (state_q == LOAD) || (state_q == CHECK);
    assign in_ready = busy && !start;
    assign accept   = in_valid && in_ready;
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign cfg_out  = cfg_q;

    always_comb begin
        state_d = state_q;
        fld_d   = fld_q;
        blk_d   = blk_q;
        xor_d   = xor_q;
        cfg_d   = cfg_q;
        err_d   = err_q;
        fire    = 1'b0;
        if (start) begin
            state_d = LOAD;
            fld_d   = FLD_X;
            blk_d   = '0;
            xor_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        fire  = 1'b1;
                        cfg_d = in_data;
                        xor_d = xor_q ^ in_data;
                        if (fld_q == LAST_FLD) begin
                            fld_d = FLD_X;
                            if (blk_q == LAST_BLK) state_d = CHECK;
                            else                   blk_d   = blk_q + BW'(1);
                        end else begin
                            fld_d = field_e'(fld_q + 2'd1);
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        cfg_d   = in_data;
                        err_d   = ((xor_q ^ in_data) != 8'h00);
                        state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fld_q   <= FLD_X;
            blk_q   <= '0;
            xor_q   <= '0;
            cfg_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fld_q   <= fld_d;
            blk_q   <= blk_d;
            xor_q   <= xor_d;
            cfg_q   <= cfg_d;
            err_q   <= err_d;
        end
    end

    cfg_strobe_decode #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .BW         (BW)
    ) u_strobe (
        .clk     (clk),
        .rst_n   (rst_n),
        .fire    (fire),
        .blk_idx (blk_q),
        .field   (fld_q),
        .set_x   (set_x),
        .set_y   (set_y),
        .set_ab  (set_ab),
        .set_cx  (set_cx)
    );

endmodule

// File: tb/tb_fabric_cfg_loader.sv
// Self-checking bench for fabric_cfg_loader: directed vector table, corner sequences, random stream vs model.
module tb_fabric_cfg_loader;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   cfg_out;
    logic [N-1:0] set_x, set_y, set_ab, set_cx;
    logic         busy, done, err;
    logic [4*N-1:0] stb;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 payload, 2 checksum, 3 done; k counts payload bytes taken
    int            m_mode, m_k;
    logic [7:0]    m_x, m_cfg;
    logic          m_err;
    logic [4*N-1:0] m_stb;

    typedef struct {
        logic st; logic vl; logic [7:0] dt;
        logic rdy; logic [4*N-1:0] stb; logic [7:0] cfg; logic bsy; logic dn; logic er;
    } vec_t;
    vec_t vecs[$];

    fabric_cfg_loader #(.NUM_BLOCKS(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cfg_out  (cfg_out),
        .set_x    (set_x),
        .set_y    (set_y),
        .set_ab   (set_ab),
        .set_cx   (set_cx),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    assign stb = {set_x, set_y, set_ab, set_cx};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // strobe position of the b-th payload byte (1-based) within {set_x,set_y,set_ab,set_cx}
    function automatic logic [4*N-1:0] sb(input int b);
        logic [4*N-1:0] v;
        int i;
        i = b - 1;
        v = '0;
        v[(3 - (i % 4)) * N + i / 4] = 1'b1;
        return v;
    endfunction

    task automatic add(input logic st, input logic vl, input logic [7:0] dt, input logic rdy,
                       input logic [4*N-1:0] s, input logic [7:0] cfg, input logic bsy,
                       input logic dn, input logic er);
        vec_t v;
        v.st = st; v.vl = vl; v.dt = dt; v.rdy = rdy; v.stb = s;
        v.cfg = cfg; v.bsy = bsy; v.dn = dn; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_x = '0; m_cfg = '0; m_err = 1'b0; m_stb = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic cyc(input logic s, input logic v, input logic [7:0] d);
        logic rdy, acc;
        start = s; in_valid = v; in_data = d;
        #1;
        rdy = (m_mode == 1 || m_mode == 2) && !s;
        chk("in_ready", in_ready, rdy);
        acc = v && rdy;
        @(posedge clk); #1;
        m_stb = '0;
        if (s) begin
            m_mode = 1; m_k = 0; m_x = '0; m_err = 1'b0;
        end else if (acc && m_mode == 1) begin
            m_stb[(3 - (m_k % 4)) * N + m_k / 4] = 1'b1;
            m_cfg = d;
            m_x   = m_x ^ d;
            m_k++;
            if (m_k == 4 * N) m_mode = 2;
        end else if (acc && m_mode == 2) begin
            m_cfg  = d;
            m_err  = (m_x ^ d) != 8'h00;
            m_mode = 3;
        end
        chk("strobes", stb, m_stb);
        chk("cfg_out", cfg_out, m_cfg);
        chk("busy", busy, (m_mode == 1 || m_mode == 2));
        chk("done", done, (m_mode == 3));
        chk("err", err, m_err);
        chk("one_hot", ($countones(stb) <= 1), 1'b1);
    endtask

    initial begin
        int n;
        logic s, v;
        logic [7:0] d;

        // Directed table: IDLE probe, good load, DONE probe, restart, gapped load with bad checksum
        add(0, 1, 8'h55, 0, '0, 8'h00, 0, 0, 0);
        add(1, 1, 8'h55, 0, '0, 8'h00, 1, 0, 0);
        for (int b = 1; b <= 32; b++) add(0, 1, 8'(b), 1, sb(b), 8'(b), 1, 0, 0);
        add(0, 1, 8'h20, 1, '0, 8'h20, 0, 1, 0);
        add(0, 1, 8'h55, 0, '0, 8'h20, 0, 1, 0);
        add(1, 0, 8'h00, 0, '0, 8'h20, 1, 0, 0);
        add(0, 1, 8'h01, 1, sb(1), 8'h01, 1, 0, 0);
        add(0, 0, 8'h77, 1, '0, 8'h01, 1, 0, 0);
        add(0, 0, 8'h77, 1, '0, 8'h01, 1, 0, 0);
        add(0, 1, 8'h02, 1, sb(2), 8'h02, 1, 0, 0);
        for (int b = 3; b <= 32; b++) add(0, 1, 8'(b), 1, sb(b), 8'(b), 1, 0, 0);
        add(0, 1, 8'h00, 1, '0, 8'h00, 0, 1, 1);
        add(0, 0, 8'h00, 0, '0, 8'h00, 0, 1, 1);

        do_reset();
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_strobes", stb, '0);
        chk("rst_cfg", cfg_out, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);

        foreach (vecs[i]) begin
            start = vecs[i].st; in_valid = vecs[i].vl; in_data = vecs[i].dt;
            #1;
            chk($sformatf("tbl%0d_ready", i), in_ready, vecs[i].rdy);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_strobes", i), stb, vecs[i].stb);
            chk($sformatf("tbl%0d_cfg", i), cfg_out, vecs[i].cfg);
            chk($sformatf("tbl%0d_busy", i), busy, vecs[i].bsy);
            chk($sformatf("tbl%0d_done", i), done, vecs[i].dn);
            chk($sformatf("tbl%0d_err", i), err, vecs[i].er);
        end

        // Restart after 10 bytes; coincident byte is refused, 0xAA lands on set_x[0]
        do_reset();
        cyc(1, 0, 8'h00);
        for (int b = 0; b < 10; b++) cyc(0, 1, 8'($urandom));
        cyc(1, 1, 8'h99);
        cyc(0, 1, 8'hAA);
        chk("restart_set_x0", stb, {{(N-1){1'b0}}, 1'b1, {(3*N){1'b0}}});
        chk("restart_cfg", cfg_out, 8'hAA);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            cyc(0, 1, 8'($urandom));
            n++;
        end
        chk("restart_len", n, 33);

        // Asynchronous reset while a strobe is high
        do_reset();
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_strobes", stb, '0);
        chk("arst_ready", in_ready, 1'b0);
        chk("arst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        chk("arst_done", done, 1'b0);
        cyc(0, 1, 8'h55);

        // Random stream with random starts, gaps and checksums
        for (int c = 0; c < 3000; c++) begin
            if (m_mode == 0 || m_mode == 3) s = ($urandom % 8) == 0;
            else                            s = ($urandom % 90) == 0;
            v = ($urandom % 4) != 0;
            d = (m_mode == 2 && ($urandom % 2) == 0) ? m_x : 8'($urandom);
            cyc(s, v, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
